bram_tdp_init: RTL and testbench

Parametrised true-dual-port block RAM with per-lane byte enables, defined same-address collision policy and an optional output register stage. After reset, a hardware sequencer loads every entry with the arithmetic pattern `OFS + i*INCR`, so stack and predictor tables can be re-seeded at run time and not only at bitstream load. It is the storage primitive under the return-address-stack logic and its companion tables.

---
 rtl/bram_tdp_init.sv | 174 +++++++++++++++++
 tb/tb_bram_tdp_init.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_init.sv
// True-dual-port RAM with per-lane byte enables and same-address collision arbitration.
// After reset, an init sequencer writes OFS + i*INCR into every entry.
module bram_tdp_init #(
    parameter int          DEPTH       = 1024,
    parameter int          WIDTH       = 36,
    parameter int          BYTE        = 9,
    parameter logic [31:0] OFS         = 32'd0,
    parameter logic [31:0] INCR        = 32'd0,
    parameter int          OUT_REG     = 0,
    parameter int          COLLIDE     = 0,
    parameter int          INIT_ON_RST = 1,
    localparam int         ADDR        = $clog2(DEPTH),
    localparam int         LANES       = WIDTH / BYTE
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic             rea,
    input  logic             reb,
    input  logic             wea,
    input  logic             web,
    input  logic [ADDR-1:0]  raddra,
    input  logic [ADDR-1:0]  raddrb,
    input  logic [ADDR-1:0]  waddra,
    input  logic [ADDR-1:0]  waddrb,
    input  logic [LANES-1:0] bea,
    input  logic [LANES-1:0] beb,
    input  logic [WIDTH-1:0] wia,
    input  logic [WIDTH-1:0] wib,
    output logic [WIDTH-1:0] doa,
    output logic [WIDTH-1:0] dob,
    output logic             vala,
    output logic             valb
);

    localparam logic [ADDR:0] LAST = (ADDR+1)'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_reg, state_next;
    logic [ADDR:0]   cnt_reg, cnt_next;
    logic [31:0]     pat;
    logic [WIDTH-1:0] init_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= (INIT_ON_RST != 0) ? ST_INIT : ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_INIT) begin
            cnt_next = cnt_reg + (ADDR+1)'(1);
            if (cnt_reg == LAST)
                state_next = ST_RUN;
        end
    end

    assign busy      = (state_reg == ST_INIT);
    assign pat       = OFS + 32'(cnt_reg) * INCR;
    assign init_word = WIDTH'(pat);

    // Port requests are dropped while the sequencer owns the RAM or reset is held.
    logic             act_a, act_b, wr_a, wr_b, same;
    logic [ADDR-1:0]  addr_a, addr_b;
    logic [WIDTH-1:0] doa1, dob1;
    logic             vala1_reg, valb1_reg;

    assign act_a  = (rea | wea) & ~busy & ~rst;
    assign act_b  = (reb | web) & ~busy & ~rst;
    assign wr_a   = wea & ~busy & ~rst;
    assign wr_b   = web & ~busy & ~rst;
    assign same   = wr_a & wr_b & (waddra == waddrb);
    assign addr_a = wea ? waddra : raddra;
    assign addr_b = web ? waddrb : raddrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            vala1_reg <= 1'b0;
            valb1_reg <= 1'b0;
        end else begin
            vala1_reg <= act_a;
            valb1_reg <= act_b;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE-1:0] mem [DEPTH];
            logic [BYTE-1:0] lane_a, lane_b, init_lane;
            logic [BYTE-1:0] dat_a, dat_b;
            logic [BYTE-1:0] da_reg, db_reg;
            logic            wa, wb, sel_a, sel_b;

            assign lane_a    = wia[gi*BYTE +: BYTE];
            assign lane_b    = wib[gi*BYTE +: BYTE];
            assign init_lane = init_word[gi*BYTE +: BYTE];
            assign wa        = wr_a & bea[gi];
            assign wb        = wr_b & beb[gi];

            // Write-through reflects the final stored lane, including the other port's
            // write to the same address; a pure reader never sees it (read-first).
            assign sel_a = wa | (wb & same);
            assign sel_b = wb | (wa & same);
            assign dat_a = (wa && !(wb && same && COLLIDE != 0)) ? lane_a : lane_b;
            assign dat_b = (wb && !(wa && same && COLLIDE == 0)) ? lane_b : lane_a;

            // The later non-blocking write wins, so the order encodes the collision winner.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (busy) begin
                        mem[cnt_reg[ADDR-1:0]] <= init_lane;
                    end else if (COLLIDE != 0) begin
                        if (wa) mem[waddra] <= lane_a;
                        if (wb) mem[waddrb] <= lane_b;
                    end else begin
                        if (wb) mem[waddrb] <= lane_b;
                        if (wa) mem[waddra] <= lane_a;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    da_reg <= '0;
                    db_reg <= '0;
                end else begin
                    if (act_a) da_reg <= sel_a ? dat_a : mem[addr_a];
                    if (act_b) db_reg <= sel_b ? dat_b : mem[addr_b];
                end
            end

            assign doa1[gi*BYTE +: BYTE] = da_reg;
            assign dob1[gi*BYTE +: BYTE] = db_reg;
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] doa2_reg, dob2_reg;
            logic             vala2_reg, valb2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    doa2_reg  <= '0;
                    dob2_reg  <= '0;
                    vala2_reg <= 1'b0;
                    valb2_reg <= 1'b0;
                end else begin
                    vala2_reg <= vala1_reg;
                    valb2_reg <= valb1_reg;
                    if (vala1_reg) doa2_reg <= doa1;
                    if (valb1_reg) dob2_reg <= dob1;
                end
            end

            assign doa  = doa2_reg;
            assign dob  = dob2_reg;
            assign vala = vala2_reg;
            assign valb = valb2_reg;
        end else begin : g_noreg
            assign doa  = doa1;
            assign dob  = dob1;
            assign vala = vala1_reg;
            assign valb = valb1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bram_tdp_init.sv
// Directed bench: two instances share stimulus; u0 is latency-1 / port A wins,
// u1 is latency-2 / port B wins. Both use DEPTH=16, OFS=0x100, INCR=3.
module tb_bram_tdp_init;

    logic        clk, rst;
    logic        rea, reb, wea, web;
    logic [3:0]  raddra, raddrb, waddra, waddrb;
    logic [3:0]  bea, beb;
    logic [35:0] wia, wib;

    logic        busy_0, vala_0, valb_0, busy_1, vala_1, valb_1;
    logic [35:0] doa_0, dob_0, doa_1, dob_1;

    int total = 0;
    int bad   = 0;

    bram_tdp_init #(.DEPTH(16), .WIDTH(36), .BYTE(9), .OFS(32'h100), .INCR(32'd3),
                    .OUT_REG(0), .COLLIDE(0), .INIT_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .busy(busy_0),
        .rea(rea), .reb(reb), .wea(wea), .web(web),
        .raddra(raddra), .raddrb(raddrb), .waddra(waddra), .waddrb(waddrb),
        .bea(bea), .beb(beb), .wia(wia), .wib(wib),
        .doa(doa_0), .dob(dob_0), .vala(vala_0), .valb(valb_0));

    bram_tdp_init #(.DEPTH(16), .WIDTH(36), .BYTE(9), .OFS(32'h100), .INCR(32'd3),
                    .OUT_REG(1), .COLLIDE(1), .INIT_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .busy(busy_1),
        .rea(rea), .reb(reb), .wea(wea), .web(web),
        .raddra(raddra), .raddrb(raddrb), .waddra(waddra), .waddrb(waddrb),
        .bea(bea), .beb(beb), .wia(wia), .wib(wib),
        .doa(doa_1), .dob(dob_1), .vala(vala_1), .valb(valb_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic idle();
        rea = 0; reb = 0; wea = 0; web = 0;
        bea = '0; beb = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle(); raddra = 0; raddrb = 0; waddra = 0; waddrb = 0; wia = 0; wib = 0;
        rst = 1;
        step(); step();
        total++;
        if ({busy_0, busy_1} !== 2'b11) begin
            bad++; $display("FAIL reset_busy got=%b exp=11", {busy_0, busy_1});
        end
        total++;
        if ({vala_0, valb_0, doa_0, dob_0} !== 74'd0) begin
            bad++; $display("FAIL reset_out_u0 got=%b/%b/%h/%h exp=0", vala_0, valb_0, doa_0, dob_0);
        end
        total++;
        if ({vala_1, valb_1, doa_1, dob_1} !== 74'd0) begin
            bad++; $display("FAIL reset_out_u1 got=%b/%b/%h/%h exp=0", vala_1, valb_1, doa_1, dob_1);
        end
        rst = 0;
        n = 0;
        while (busy_0 === 1'b1 && n < 100) begin
            step(); n++;
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL init_busy_len got=%0d exp=16", n);
        end
        total++;
        if (busy_1 !== 1'b0) begin
            bad++; $display("FAIL init_busy_u1 got=%b exp=0", busy_1);
        end
    endtask

    task automatic test_init_pattern();
        rea = 1; raddra = 5; reb = 1; raddrb = 15;
        step(); idle();
        total++;
        if ({vala_0, doa_0} !== {1'b1, 36'h10F}) begin
            bad++; $display("FAIL init_rd5_u0 got=%b/%h exp=1/10f", vala_0, doa_0);
        end
        total++;
        if ({valb_0, dob_0} !== {1'b1, 36'h12D}) begin
            bad++; $display("FAIL init_rd15_u0 got=%b/%h exp=1/12d", valb_0, dob_0);
        end
        total++;
        if (vala_1 !== 1'b0) begin
            bad++; $display("FAIL oreg_early_u1 got=%b exp=0", vala_1);
        end
        step();
        total++;
        if ({vala_0, doa_0} !== {1'b0, 36'h10F}) begin
            bad++; $display("FAIL hold_u0 got=%b/%h exp=0/10f", vala_0, doa_0);
        end
        total++;
        if ({vala_1, doa_1, valb_1, dob_1} !== {1'b1, 36'h10F, 1'b1, 36'h12D}) begin
            bad++; $display("FAIL init_rd_u1 got=%b/%h/%b/%h exp=1/10f/1/12d", vala_1, doa_1, valb_1, dob_1);
        end
        step();
        total++;
        if ({vala_1, doa_1} !== {1'b0, 36'h10F}) begin
            bad++; $display("FAIL hold_u1 got=%b/%h exp=0/10f", vala_1, doa_1);
        end
    endtask

    task automatic test_byte_enable();
        wea = 1; waddra = 2; wia = 36'hFFFFFFFFF; bea = 4'b0101;
        step(); idle();
        total++;
        if ({vala_0, doa_0} !== {1'b1, 36'h007FC01FF}) begin
            bad++; $display("FAIL be_wt_u0 got=%b/%h exp=1/007fc01ff", vala_0, doa_0);
        end
        step();
        total++;
        if ({vala_1, doa_1} !== {1'b1, 36'h007FC01FF}) begin
            bad++; $display("FAIL be_wt_u1 got=%b/%h exp=1/007fc01ff", vala_1, doa_1);
        end
        rea = 1; raddra = 2;
        step(); idle();
        total++;
        if (doa_0 !== 36'h007FC01FF) begin
            bad++; $display("FAIL be_rd_u0 got=%h exp=007fc01ff", doa_0);
        end
        step();
        total++;
        if (doa_1 !== 36'h007FC01FF) begin
            bad++; $display("FAIL be_rd_u1 got=%h exp=007fc01ff", doa_1);
        end
    endtask

    task automatic test_collision();
        wea = 1; web = 1; waddra = 9; waddrb = 9;
        wia = 36'hAAA; wib = 36'h555; bea = 4'hF; beb = 4'hF;
        step(); idle();
        total++;
        if ({doa_0, dob_0} !== {36'hAAA, 36'hAAA}) begin
            bad++; $display("FAIL coll_full_u0 got=%h/%h exp=aaa/aaa", doa_0, dob_0);
        end
        step();
        total++;
        if ({doa_1, dob_1} !== {36'h555, 36'h555}) begin
            bad++; $display("FAIL coll_full_u1 got=%h/%h exp=555/555", doa_1, dob_1);
        end
        // Lane 1 is enabled on both ports; lanes 0 and 2-3 on one port only.
        wea = 1; web = 1; waddra = 10; waddrb = 10;
        wia = 36'hFFFFFFFFF; wib = 36'h0; bea = 4'b0011; beb = 4'b1110;
        step(); idle();
        total++;
        if ({doa_0, dob_0} !== {36'h3FFFF, 36'h3FFFF}) begin
            bad++; $display("FAIL coll_lane_u0 got=%h/%h exp=3ffff/3ffff", doa_0, dob_0);
        end
        step();
        total++;
        if ({doa_1, dob_1} !== {36'h1FF, 36'h1FF}) begin
            bad++; $display("FAIL coll_lane_u1 got=%h/%h exp=1ff/1ff", doa_1, dob_1);
        end
        rea = 1; raddra = 9; reb = 1; raddrb = 10;
        step(); idle();
        total++;
        if ({doa_0, dob_0} !== {36'hAAA, 36'h3FFFF}) begin
            bad++; $display("FAIL coll_rd_u0 got=%h/%h exp=aaa/3ffff", doa_0, dob_0);
        end
        step();
        total++;
        if ({doa_1, dob_1} !== {36'h555, 36'h1FF}) begin
            bad++; $display("FAIL coll_rd_u1 got=%h/%h exp=555/1ff", doa_1, dob_1);
        end
    endtask

    task automatic test_cross_port();
        wea = 1; waddra = 7; wia = 36'h42; bea = 4'hF;
        reb = 1; raddrb = 7;
        step(); idle();
        total++;
        if ({doa_0, dob_0} !== {36'h42, 36'h115}) begin
            bad++; $display("FAIL cross_u0 got=%h/%h exp=42/115", doa_0, dob_0);
        end
        step();
        total++;
        if ({doa_1, dob_1} !== {36'h42, 36'h115}) begin
            bad++; $display("FAIL cross_u1 got=%h/%h exp=42/115", doa_1, dob_1);
        end
        reb = 1; raddrb = 7;
        step(); idle();
        total++;
        if ({valb_0, dob_0} !== {1'b1, 36'h42}) begin
            bad++; $display("FAIL cross_rd_u0 got=%b/%h exp=1/42", valb_0, dob_0);
        end
        step();
        total++;
        if ({valb_1, dob_1} !== {1'b1, 36'h42}) begin
            bad++; $display("FAIL cross_rd_u1 got=%b/%h exp=1/42", valb_1, dob_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                rea = 1; raddra = 4'(11 + i);
            end else begin
                idle();
            end
            step();
            if (i < 4) begin
                e = 36'h100 + 36'(3 * (11 + i));
                total++;
                if ({vala_0, doa_0} !== {1'b1, e}) begin
                    bad++; $display("FAIL b2b_u0[%0d] got=%b/%h exp=1/%h", i, vala_0, doa_0, e);
                end
            end
            if (i > 0) begin
                e = 36'h100 + 36'(3 * (10 + i));
                total++;
                if ({vala_1, doa_1} !== {1'b1, e}) begin
                    bad++; $display("FAIL b2b_u1[%0d] got=%b/%h exp=1/%h", i, vala_1, doa_1, e);
                end
            end
        end
        step();
        total++;
        if ({vala_1, doa_1} !== {1'b0, 36'h12A}) begin
            bad++; $display("FAIL b2b_hold_u1 got=%b/%h exp=0/12a", vala_1, doa_1);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        idle();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 8; i++) step();
        rst = 1; step();
        total++;
        if ({busy_0, busy_1} !== 2'b11) begin
            bad++; $display("FAIL mid_rst_busy got=%b exp=11", {busy_0, busy_1});
        end
        rst = 0;
        wea = 1; waddra = 3; wia = 36'h0; bea = 4'hF;
        web = 1; waddrb = 2; wib = 36'h0; beb = 4'hF;
        n = 0;
        while (busy_0 === 1'b1 && n < 100) begin
            step(); n++;
            total++;
            if ({vala_0, valb_0, vala_1, valb_1} !== 4'b0000) begin
                bad++; $display("FAIL busy_drop[%0d] got=%b exp=0000", n, {vala_0, valb_0, vala_1, valb_1});
            end
        end
        idle();
        total++;
        if (n != 16) begin
            bad++; $display("FAIL mid_busy_len got=%0d exp=16", n);
        end
        rea = 1; raddra = 3; reb = 1; raddrb = 7;
        step();
        raddra = 2; raddrb = 9;
        total++;
        if ({doa_0, dob_0} !== {36'h109, 36'h115}) begin
            bad++; $display("FAIL reinit_a_u0 got=%h/%h exp=109/115", doa_0, dob_0);
        end
        step(); idle();
        total++;
        if ({doa_0, dob_0} !== {36'h106, 36'h11B}) begin
            bad++; $display("FAIL reinit_b_u0 got=%h/%h exp=106/11b", doa_0, dob_0);
        end
        total++;
        if ({doa_1, dob_1} !== {36'h109, 36'h115}) begin
            bad++; $display("FAIL reinit_a_u1 got=%h/%h exp=109/115", doa_1, dob_1);
        end
        step();
        total++;
        if ({doa_1, dob_1} !== {36'h106, 36'h11B}) begin
            bad++; $display("FAIL reinit_b_u1 got=%h/%h exp=106/11b", doa_1, dob_1);
        end
    endtask

    initial begin
        test_reset();
        test_init_pattern();
        test_byte_enable();
        test_collision();
        test_cross_port();
        test_back_to_back();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
